// File: rtl/up_down_counter.sv
// Up/down counter with load, clear, boundary carry pulse and sticky overflow.
// All arithmetic comes from a single incrementer-decrementer whose carry
// network can be built serial, Brent-Kung or Sklansky.

// Incrementer-decrementer: Z = A + CI (DEC=0) or A - CI (DEC=1), CO on boundary.
module IncDecC #(
  parameter int unsigned width = 8,
  parameter int unsigned speed = 0
) (
  input  logic [width-1:0] A,
  input  logic             CI,
  input  logic             DEC,
  output logic [width-1:0] Z,
  output logic             CO
);

  localparam int unsigned LVLS = (width > 1) ? $clog2(width) : 1;

  logic [width-1:0] w_t;  // per-bit propagate: all-ones run (inc) or all-zeros run (dec)
  logic [width-1:0] w_p;  // w_p[i] = AND of w_t[0..i]
  logic [width-1:0] w_c;  // carry/borrow into each bit

  assign w_t = A ^ {width{DEC}};

  generate
    if (speed == 0) begin : g_serial
      // Ripple prefix AND, one level per bit.
      always_comb begin
        w_p = w_t;
        for (int i = 1; i < int'(width); i++) begin
          w_p[i] = w_p[i] & w_p[i-1];
        end
      end
    end else if (speed == 1) begin : g_brent_kung
      // Up-sweep builds power-of-two spans, down-sweep fills the gaps.
      always_comb begin
        w_p = w_t;
        for (int l = 0; l < int'(LVLS); l++) begin
          for (int i = 0; i < int'(width); i++) begin
            if (((i + 1) % (1 << (l + 1))) == 0) begin
              w_p[i] = w_p[i] & w_p[i - (1 << l)];
            end
          end
        end
        for (int l = int'(LVLS) - 1; l >= 0; l--) begin
          for (int i = 0; i < int'(width); i++) begin
            if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && (i >= (1 << (l + 1)))) begin
              w_p[i] = w_p[i] & w_p[i - (1 << l)];
            end
          end
        end
      end
    end else begin : g_sklansky
      // Divide-and-conquer: each upper half picks up the last bit of its lower half.
      always_comb begin
        w_p = w_t;
        for (int l = 0; l < int'(LVLS); l++) begin
          for (int i = 0; i < int'(width); i++) begin
            if (((i >> l) & 1) == 1) begin
              w_p[i] = w_p[i] & w_p[((i >> l) << l) - 1];
            end
          end
        end
      end
    end
  endgenerate

  assign w_c = {w_p[width-2:0], 1'b1} & {width{CI}};
  assign Z   = A ^ w_c;
  assign CO  = CI & w_p[width-1];

endmodule

// Counter top: priority RST_N > CLR > LD > EN > hold.
module up_down_counter #(
  parameter int unsigned width = 8,
  parameter int unsigned speed = 0,
  parameter int unsigned sat   = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             LD,
  input  logic [width-1:0] D,
  input  logic             EN,
  input  logic             DEC,
  output logic [width-1:0] Q,
  output logic             CO,
  output logic             TC,
  output logic             OVF
);

  localparam bit SAT_EN = (sat != 0);

  logic [width-1:0] r_q;
  logic             r_co;
  logic             r_ovf;
  logic [width-1:0] w_z;
  logic             w_step_co;
  logic [width-1:0] w_q_nxt;
  logic             w_co_nxt;
  logic             w_ovf_nxt;

  IncDecC #(
    .width (width),
    .speed (speed)
  ) u_incdec (
    .A   (r_q),
    .CI  (1'b1),
    .DEC (DEC),
    .Z   (w_z),
    .CO  (w_step_co)
  );

  // Next-state selection; a saturating counter refuses the boundary step.
  always_comb begin
    w_q_nxt   = r_q;
    w_co_nxt  = 1'b0;
    w_ovf_nxt = r_ovf;
    if (CLR) begin
      w_q_nxt   = '0;
      w_ovf_nxt = 1'b0;
    end else if (LD) begin
      w_q_nxt   = D;
      w_ovf_nxt = 1'b0;
    end else if (EN) begin
      if (w_step_co) begin
        w_co_nxt  = 1'b1;
        w_ovf_nxt = 1'b1;
        if (!SAT_EN) begin
          w_q_nxt = w_z;
        end
      end else begin
        w_q_nxt = w_z;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_q   <= '0;
      r_co  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_co  <= w_co_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign Q   = r_q;
  assign CO  = r_co;
  assign OVF = r_ovf;
  assign TC  = DEC ? (r_q == '0) : (r_q == '1);

endmodule

// File: tb/tb_up_down_counter.sv
// Scoreboard bench: three counters (serial/wrap, Brent-Kung/wrap,
// Sklansky/saturate) share one stimulus stream; expected responses are queued
// at drive time and checked by an independent monitor after each edge.
module tb_up_down_counter;

  logic       CLK = 1'b0;
  logic       RST_N, CLR, LD, EN, DEC;
  logic [7:0] D;

  logic [7:0] q0, q1, q2;
  logic       co0, co1, co2, tc0, tc1, tc2, ovf0, ovf1, ovf2;

  typedef struct {
    int         idx;
    logic       dec;
    logic [7:0] qw;
    logic       cow;
    logic       ovfw;
    logic [7:0] qs;
    logic       cos;
    logic       ovfs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;

  always #5 CLK = ~CLK;

  up_down_counter #(.width(8), .speed(0), .sat(0)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LD(LD), .D(D), .EN(EN), .DEC(DEC),
    .Q(q0), .CO(co0), .TC(tc0), .OVF(ovf0));

  up_down_counter #(.width(8), .speed(1), .sat(0)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LD(LD), .D(D), .EN(EN), .DEC(DEC),
    .Q(q1), .CO(co1), .TC(tc1), .OVF(ovf1));

  up_down_counter #(.width(8), .speed(2), .sat(1)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LD(LD), .D(D), .EN(EN), .DEC(DEC),
    .Q(q2), .CO(co2), .TC(tc2), .OVF(ovf2));

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, want);
    end
  endtask

  // Monitor: every edge the counters present a result; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q0",   e.idx, q0,          e.qw);
        chk("co0",  e.idx, 8'(co0),     8'(e.cow));
        chk("ovf0", e.idx, 8'(ovf0),    8'(e.ovfw));
        chk("tc0",  e.idx, 8'(tc0),     8'(e.dec ? (e.qw == 8'h00) : (e.qw == 8'hFF)));
        chk("q1",   e.idx, q1,          e.qw);
        chk("co1",  e.idx, 8'(co1),     8'(e.cow));
        chk("ovf1", e.idx, 8'(ovf1),    8'(e.ovfw));
        chk("tc1",  e.idx, 8'(tc1),     8'(e.dec ? (e.qw == 8'h00) : (e.qw == 8'hFF)));
        chk("q2",   e.idx, q2,          e.qs);
        chk("co2",  e.idx, 8'(co2),     8'(e.cos));
        chk("ovf2", e.idx, 8'(ovf2),    8'(e.ovfs));
        chk("tc2",  e.idx, 8'(tc2),     8'(e.dec ? (e.qs == 8'h00) : (e.qs == 8'hFF)));
      end
    end
  end

  // Drive one vector on the falling edge and queue what the next rising edge must produce.
  task automatic step(input logic rst_n, input logic clr, input logic ld,
                      input logic en, input logic dec, input logic [7:0] d,
                      input logic [7:0] qw, input logic cow, input logic ovfw,
                      input logic [7:0] qs, input logic cos, input logic ovfs);
    exp_t e;
    @(negedge CLK);
    RST_N = rst_n; CLR = clr; LD = ld; EN = en; DEC = dec; D = d;
    e.idx = vec_n; e.dec = dec;
    e.qw = qw; e.cow = cow; e.ovfw = ovfw;
    e.qs = qs; e.cos = cos; e.ovfs = ovfs;
    exp_q.push_back(e);
    vec_n++;
  endtask

  initial begin
    RST_N = 1'b0; CLR = 1'b0; LD = 1'b0; EN = 1'b0; DEC = 1'b0; D = 8'h00;

    //    rst clr ld en dec d       qw   cow ovfw  qs   cos ovfs
    // reset, TC follows DEC
    step(0, 0, 0, 1, 0, 8'h00,  8'h00, 0, 0,  8'h00, 0, 0);
    step(0, 0, 0, 0, 1, 8'h00,  8'h00, 0, 0,  8'h00, 0, 0);
    // count up 1,2,3
    step(1, 0, 0, 1, 0, 8'h00,  8'h01, 0, 0,  8'h01, 0, 0);
    step(1, 0, 0, 1, 0, 8'h00,  8'h02, 0, 0,  8'h02, 0, 0);
    step(1, 0, 0, 1, 0, 8'h00,  8'h03, 0, 0,  8'h03, 0, 0);
    // top boundary: wrap vs saturate, CO one-cycle, OVF sticky
    step(1, 0, 1, 0, 0, 8'hFE,  8'hFE, 0, 0,  8'hFE, 0, 0);
    step(1, 0, 0, 1, 0, 8'h00,  8'hFF, 0, 0,  8'hFF, 0, 0);
    step(1, 0, 0, 1, 0, 8'h00,  8'h00, 1, 1,  8'hFF, 1, 1);
    step(1, 0, 0, 0, 0, 8'h00,  8'h00, 0, 1,  8'hFF, 0, 1);
    step(1, 0, 0, 1, 0, 8'h00,  8'h01, 0, 1,  8'hFF, 1, 1);
    // bottom boundary counting down, repeated saturated steps
    step(1, 0, 1, 1, 1, 8'h01,  8'h01, 0, 0,  8'h01, 0, 0);
    step(1, 0, 0, 1, 1, 8'h00,  8'h00, 0, 0,  8'h00, 0, 0);
    step(1, 0, 0, 1, 1, 8'h00,  8'hFF, 1, 1,  8'h00, 1, 1);
    step(1, 0, 0, 1, 1, 8'h00,  8'hFE, 0, 1,  8'h00, 1, 1);
    // CLR beats LD and EN, then LD beats EN
    step(1, 1, 1, 1, 0, 8'h55,  8'h00, 0, 0,  8'h00, 0, 0);
    step(1, 0, 1, 1, 0, 8'h55,  8'h55, 0, 0,  8'h55, 0, 0);
    // hold with EN low while DEC flips, then reverse direction without penalty
    step(1, 0, 0, 0, 1, 8'hAA,  8'h55, 0, 0,  8'h55, 0, 0);
    step(1, 0, 0, 1, 1, 8'h00,  8'h54, 0, 0,  8'h54, 0, 0);
    step(1, 0, 0, 1, 0, 8'h00,  8'h55, 0, 0,  8'h55, 0, 0);
    // reset mid-count discards the step; next step starts at 0
    step(1, 0, 1, 0, 0, 8'h7F,  8'h7F, 0, 0,  8'h7F, 0, 0);
    step(1, 0, 0, 1, 0, 8'h00,  8'h80, 0, 0,  8'h80, 0, 0);
    step(0, 0, 0, 1, 0, 8'h00,  8'h00, 0, 0,  8'h00, 0, 0);
    step(1, 0, 0, 1, 0, 8'h00,  8'h01, 0, 0,  8'h01, 0, 0);

    // full upward sweep from 0 exercises every carry span
    step(1, 0, 1, 0, 0, 8'h00,  8'h00, 0, 0,  8'h00, 0, 0);
    for (int i = 1; i <= 256; i++) begin
      step(1, 0, 0, 1, 0, 8'h00,
           8'(i % 256), (i == 256), (i == 256),
           (i >= 255) ? 8'hFF : 8'(i), (i == 256), (i == 256));
    end
    // full downward sweep from all-ones exercises every borrow span
    step(1, 0, 1, 0, 1, 8'hFF,  8'hFF, 0, 0,  8'hFF, 0, 0);
    for (int i = 1; i <= 256; i++) begin
      step(1, 0, 0, 1, 1, 8'h00,
           8'((512 + 255 - i) % 256), (i == 256), (i == 256),
           (i >= 255) ? 8'h00 : 8'(255 - i), (i == 256), (i == 256));
    end

    // drain with a bounded wait
    begin
      int waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge CLK);
        #2;
        waited++;
      end
      if (exp_q.size() > 0) begin
        errors++;
        checks++;
        $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/up_down_counter.md
UP_DOWN_COUNTER -- requirements
Module: up_down_counter

Interface
REQ-001 The block SHALL have parameter width, default 8, meaning counter word width (legal range 2..64).
REQ-002 The block SHALL have parameter speed, default 0, meaning prefix-structure selector passed unchanged to the incrementer-decrementer (0 serial, 1 Brent-Kung, 2 Sklansky).
REQ-003 The block SHALL have parameter sat, default 0, meaning 0 = wrap at boundaries, 1 = saturate at boundaries.
REQ-004 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 CLR  input  1  synchronous clear of count and flags.
REQ-007 LD  input  1  synchronous load of D into count.
REQ-008 D  input  width  load value.
REQ-009 EN  input  1  count enable, one step per enabled cycle.
REQ-010 DEC  input  1  direction: 0 = count up, 1 = count down.
REQ-011 Q  output  width  registered count value.
REQ-012 CO  output  1  registered one-cycle pulse: the previous step crossed a boundary (wrap or saturation attempt).
REQ-013 TC  output  1  combinational terminal count: Q == all-ones when DEC=0, Q == 0 when DEC=1.
REQ-014 OVF  output  1  registered sticky flag: a boundary crossing has occurred since the last clear or load.

Function
REQ-015 The next-count datapath SHALL be one IncDecC instance with width=width, speed=speed, A=Q, CI=1, DEC=DEC; its Z and CO SHALL be the only arithmetic source.
REQ-016 Per-cycle priority SHALL be RST_N low > CLR > LD > EN > hold.
REQ-017 On CLR, Q SHALL be set to 0, CO to 0 and OVF to 0 on the next edge.
REQ-018 On LD without CLR, Q SHALL be set to D, CO to 0 and OVF to 0 on the next edge, regardless of EN.
REQ-019 On EN without CLR or LD, with the IncDecC carry-out at 0, Q SHALL be set to Q+1 (DEC=0) or Q-1 (DEC=1) and CO to 0.
REQ-020 On EN with the IncDecC carry-out at 1 and sat=0, Q SHALL take the IncDecC result (all-ones+1 -> 0, 0-1 -> all-ones); CO SHALL be 1 and OVF SHALL be set.
REQ-021 On EN with the IncDecC carry-out at 1 and sat=1, Q SHALL hold its value; CO SHALL be 1 and OVF SHALL be set.
REQ-022 With EN low and no CLR or LD, Q and OVF SHALL hold and CO SHALL be 0.
REQ-023 Latency: a change on CLR, LD, or EN SHALL be visible on Q, CO, and OVF exactly one CLK edge later; there SHALL be no combinational path from any input to Q, CO, or OVF.
REQ-024 TC SHALL depend only on Q and DEC and SHALL be free of glitches caused by EN, LD, or CLR.
REQ-025 A DEC change takes effect in the same cycle; there SHALL be no extra penalty cycle for reversing direction.
REQ-026 CO SHALL be high for exactly one cycle per boundary step; consecutive saturated steps SHALL produce CO high on each of those cycles.

Reset
REQ-027 When RST_N is sampled low, Q SHALL be set to 0, CO to 0 and OVF to 0, overriding all other inputs.
REQ-028 Reset asserted mid-count SHALL discard the pending step; the first step after RST_N rises SHALL start from 0.
REQ-029 TC immediately after reset SHALL read 1 if DEC=1 and 0 if DEC=0.

Verification (width=8)
REQ-030 Reset, then EN=1, DEC=0 for 3 cycles -> Q=1,2,3; CO=0; OVF=0; TC=0.
REQ-031 LD with D=0xFE, then EN=1, DEC=0, sat=0 for 2 cycles -> Q=0xFF with TC=1, then Q=0x00 with CO=1 for one cycle and OVF=1 sticky.
REQ-032 sat=1, LD with D=0x01, then EN=1, DEC=1 for 3 cycles -> Q=0x00, 0x00, 0x00; CO=0, 1, 1; OVF=1 from the second step onward.
REQ-033 Same cycle CLR=1, LD=1, D=0x55, EN=1 -> Q=0x00 and OVF cleared (CLR wins); next cycle LD=1, EN=1, D=0x55 -> Q=0x55 (LD wins over EN).
REQ-034 Q=0x80 while counting up, RST_N=0 for one cycle with EN=1 -> Q=0x00, CO=0, OVF=0; after release with EN=1 -> Q=0x01.
REQ-035 Random CLR, LD, EN, DEC, and D for 10k cycles for each speed in {0,1,2} and each sat in {0,1} -> Q, CO, and OVF match a cycle-accurate reference model every cycle.
